// File: rtl/matinv2.sv
// matinv2: fixed-point 2x2 inverse via restoring reciprocal and shared multiplier.
// Define MATINV2_ROUND_EN for round-to-nearest reciprocal and round-half-up products.
module matinv2_mul #(
    parameter int DW = 16,
    parameter int BP = 8
) (
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    output logic [DW-1:0] p
);
    localparam logic signed [2*DW-1:0] RND =
        (BP > 0) ? ((2*DW)'(1) << (BP - 1)) : '0;

    logic signed [2*DW-1:0] prod;
    logic signed [2*DW-1:0] sh;

    always_comb begin
        prod = $signed(x) * $signed(y);
`ifdef MATINV2_ROUND_EN
        prod = prod + RND;
`endif
        sh = prod >>> BP;
        p  = sh[DW-1:0];
    end
endmodule

module matinv2 #(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH*4-1:0] a,
    input  logic [DATA_WIDTH-1:0]   det,
    output logic                    busy,
    output logic                    complete,
    output logic                    singular,
    output logic [DATA_WIDTH*4-1:0] inv
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [2*DW-1:0] NUM  = (2*DW)'(1) << (2 * BIN_POS);
    localparam logic [DW-1:0]   NUM_HI = NUM[2*DW-1:DW];
    localparam logic [DW-1:0]   NUM_LO = NUM[DW-1:0];
    localparam logic [DW-1:0]   QMAX = {1'b0, {(DW-1){1'b1}}};

    if (MATRIX_SIZE != 2) begin : g_size_chk
        $error("matinv2 supports MATRIX_SIZE == 2 only");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_MUL,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [DW*4-1:0]   a_q;
    logic [DW-1:0]     det_q;
    logic [DW-1:0]     dmag_q;
    logic              neg_q;
    logic              ovf_q;
    logic [DW-1:0]     rem_q;
    logic [DW-1:0]     dvd_q;
    logic [DW-1:0]     quo_q;
    logic [CW-1:0]     cnt_q;
    logic [DW-1:0]     r_q;
    logic [1:0]        idx_q;

    logic [DW:0]       trial;
    logic              ge;
    logic [DW:0]       rem_nx;
    logic [DW:0]       q_ext;
    logic              sat;
    logic [DW-1:0]     qmag;
    logic [DW-1:0]     r_fin;
    logic [DW-1:0]     dmag_d;
    logic [DW-1:0]     mx;
    logic [DW-1:0]     mp;

    // One quotient bit per cycle; remainder stays below |det| unless overflowed.
    always_comb begin
        trial  = {rem_q, dvd_q[DW-1]};
        ge     = trial >= {1'b0, dmag_q};
        rem_nx = ge ? (trial - {1'b0, dmag_q}) : trial;
        q_ext  = {1'b0, quo_q[DW-2:0], ge};
`ifdef MATINV2_ROUND_EN
        if ({rem_nx, 1'b0} >= {2'b00, dmag_q}) begin
            q_ext = q_ext + (DW+1)'(1);
        end
`endif
        sat   = ovf_q || (q_ext > {1'b0, QMAX});
        qmag  = sat ? QMAX : q_ext[DW-1:0];
        r_fin = neg_q ? (-qmag) : qmag;
    end

    always_comb begin
        dmag_d = det_q[DW-1] ? (-det_q) : det_q;
        case (idx_q)
            2'd0:    mx = a_q[3*DW +: DW];
            2'd1:    mx = -a_q[1*DW +: DW];
            2'd2:    mx = -a_q[2*DW +: DW];
            default: mx = a_q[0 +: DW];
        endcase
    end

    matinv2_mul #(
        .DW(DW),
        .BP(BIN_POS)
    ) u_mul (
        .x(mx),
        .y(r_q),
        .p(mp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            det_q    <= '0;
            dmag_q   <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            rem_q    <= '0;
            dvd_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            r_q      <= '0;
            idx_q    <= '0;
            busy     <= 1'b0;
            complete <= 1'b0;
            singular <= 1'b0;
            inv      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        det_q    <= det;
                        complete <= 1'b0;
                        singular <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (det_q == '0) begin
                        singular <= 1'b1;
                        inv      <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        neg_q   <= det_q[DW-1];
                        dmag_q  <= dmag_d;
                        ovf_q   <= NUM_HI >= dmag_d;
                        rem_q   <= NUM_HI;
                        dvd_q   <= NUM_LO;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_nx[DW-1:0];
                    dvd_q <= {dvd_q[DW-2:0], 1'b0};
                    quo_q <= {quo_q[DW-2:0], ge};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1)) begin
                        r_q     <= r_fin;
                        idx_q   <= '0;
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    inv[int'(idx_q)*DW +: DW] <= mp;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    complete <= 1'b1;
                    busy     <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matinv2.sv
// Scoreboarded random/directed bench for matinv2.
module tb_matinv2;
    localparam int DW = 16;
    localparam int BP = 8;

    typedef struct {
        logic [63:0] inv;
        logic        sing;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] a = '0;
    logic [15:0] det = '0;
    logic        busy;
    logic        complete;
    logic        singular;
    logic [63:0] inv;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic cmp_prev = 1'b0;
    exp_t sb[$];

    matinv2 #(.DATA_WIDTH(DW), .BIN_POS(BP), .MATRIX_SIZE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .det(det),
        .busy(busy), .complete(complete), .singular(singular), .inv(inv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    // Reference: reciprocal by integer division, then each adjugate term scaled.
    function automatic exp_t model(input logic [63:0] av, input logic [15:0] dv, input int c0);
        exp_t e;
        longint d, m, q, rm, r, p;
        logic [15:0] el[4];
        logic [15:0] t;
        d = sx(dv);
        e.inv = '0;
        if (d == 0) begin
            e.sing = 1'b1;
            e.done_cyc = c0 + 2;
            return e;
        end
        e.sing = 1'b0;
        e.done_cyc = c0 + DW + 6;
        m = (d < 0) ? -d : d;
        q = (longint'(1) << (2 * BP)) / m;
        rm = (longint'(1) << (2 * BP)) % m;
`ifdef MATINV2_ROUND_EN
        if (2 * rm >= m) q++;
`endif
        if (q > 32767) q = 32767;
        r = (d < 0) ? -q : q;
        el[0] = av[48 +: 16];
        t = -av[16 +: 16];
        el[1] = t;
        t = -av[32 +: 16];
        el[2] = t;
        el[3] = av[0 +: 16];
        for (int k = 0; k < 4; k++) begin
            p = sx(el[k]) * r;
`ifdef MATINV2_ROUND_EN
            p = p + (longint'(1) << (BP - 1));
`endif
            p = p >>> BP;
            e.inv[k*16 +: 16] = p[15:0];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst && complete && !cmp_prev) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("inv", inv, e.inv);
                chk("singular", 64'(singular), 64'(e.sing));
                chk("latency", 64'(cyc), 64'(e.done_cyc));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
        cmp_prev <= complete;
    end

    task automatic run(input logic [63:0] av, input logic [15:0] dv, input bit poke);
        @(negedge clk);
        a = av;
        det = dv;
        start = 1'b1;
        sb.push_back(model(av, dv, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        a = {$urandom, $urandom};
        det = 16'($urandom);
        if (poke && dv != 0) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 40 && !complete; i++) @(negedge clk);
        chk("done_timeout", 64'(complete), 64'd1);
    endtask

    function automatic logic [63:0] mk(input logic [15:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    initial begin
        logic [63:0] ra;
        logic [15:0] rd;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_complete", 64'(complete), 64'd0);
        chk("rst_singular", 64'(singular), 64'd0);
        chk("rst_inv", inv, 64'd0);
        rst = 1'b1;

        run(mk(16'h0100, 0, 0, 16'h0100), 16'h0100, 0);
        chk("identity", inv, mk(16'h0100, 0, 0, 16'h0100));
        run(mk(16'h0200, 0, 0, 16'h0400), 16'h0800, 1);
        chk("diag", inv, mk(16'h0080, 0, 0, 16'h0040));
        run(mk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 16'hFE00, 0);
        chk("full", inv, mk(16'hFE00, 16'h0100, 16'h0180, 16'hFF80));
        run(mk(16'h1234, 16'h0055, 16'h8000, 16'h7FFF), 16'h0000, 0);
        chk("sing_inv", inv, 64'd0);
        chk("sing_flag", 64'(singular), 64'd1);
        run(mk(16'h0100, 0, 0, 16'h0100), 16'h0001, 0);
        chk("sat_r", 64'(inv[15:0]), 64'h7FFF);
        run(mk(16'h0100, 0, 0, 16'h0100), 16'h0300, 0);
        chk("r_300", 64'(inv[15:0]), 64'h0055);
        run(mk(16'h0100, 0, 0, 16'h0100), 16'h0280, 1);
        chk("r_280", 64'(inv[15:0]), 64'h0066);
        run(mk(16'h8000, 16'h8000, 16'h0100, 16'h0100), 16'h8000, 0);
        run(mk(16'h0100, 0, 0, 16'h0100), 16'hFFFF, 0);

        // Abort mid-division, with an ignored start while busy.
        @(negedge clk);
        a = mk(16'h0100, 0, 0, 16'h0100);
        det = 16'h0100;
        start = 1'b1;
        sb.push_back(model(a, det, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_complete", 64'(complete), 64'd0);
        chk("abort_singular", 64'(singular), 64'd0);
        chk("abort_inv", inv, 64'd0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle_complete", 64'(complete), 64'd0);
        run(mk(16'h0100, 0, 0, 16'h0100), 16'h0100, 0);
        chk("post_abort_identity", inv, mk(16'h0100, 0, 0, 16'h0100));

        for (int n = 0; n < 40; n++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rd = 16'h0000;
                1: rd = 16'($urandom_range(1, 512));
                2: rd = -16'($urandom_range(1, 4096));
                default: rd = 16'($urandom);
            endcase
            run(ra, rd, n[0]);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
